// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single line-fill memory port between the instruction cache
// (line reads only) and the data cache (line reads and write-backs). One
// requester owns the port at a time. The grant is held until memory returns
// its one-cycle ready pulse. A single DONE bubble follows each transfer so the
// finished requester can drop its request before the next arbitration.
//
// Optional feature:
//   MEM_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                              (last_gnt_q resets to IC, so the first tie
//                              goes to DC).
//                  undefined -> fixed priority, DC wins a tie.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ic_req_i / ic_addr_i       ICache line-read request (held until ready)
//   ic_ready_o / ic_data_o     ICache completion pulse and line data
//   dc_req_i / dc_we_i         DCache request, 1 = write-back, 0 = line read
//   dc_addr_i / dc_wdata_i     DCache address and write-back line
//   dc_ready_o / dc_data_o     DCache completion pulse and read data
//   mem_req_o / mem_we_o       memory request (held until mem_ready_i), write
//   mem_addr_o / mem_wdata_o   line-aligned address, write data
//   mem_ready_i / mem_rdata_i  memory completion pulse and read line
//   gnt_o                      current owner: 01 = IC, 10 = DC, 00 = none
//   err_o                      sticky timeout flag (wait reached MAX_WAIT)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int MAX_WAIT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_ready_o,
  output logic [LINE_W-1:0] ic_data_o,

  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_ready_o,
  output logic [LINE_W-1:0] dc_data_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_rdata_i,

  output logic [1:0]        gnt_o,
  output logic              err_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IC = 2'd1,
    GNT_DC = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic [CNT_W-1:0]    wait_cnt_d;
  logic                err_q;
  logic                err_d;
  logic [1:0]          gnt_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [LINE_W-1:0]   mem_wdata_q;
  logic                pick_dc_d;

  // The low four address bits are replaced by zero (line alignment) and are
  // therefore never looked at.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{ic_addr_i[3:0], dc_addr_i[3:0]};

`ifdef MEM_ARB_RR_EN
  // 1 = DC held the most recent grant, 0 = IC.
  logic last_gnt_q;

  always_comb begin
    pick_dc_d = dc_req_i;
    if (dc_req_i && ic_req_i) begin
      pick_dc_d = ~last_gnt_q;
    end
  end
`else
  always_comb begin
    pick_dc_d = dc_req_i;
  end
`endif

  // Saturating wait counter; err is raised on the edge the count reaches
  // MAX_WAIT and never cleared except by reset.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (wait_cnt_q != CNT_W'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    err_d = err_q | (wait_cnt_d == CNT_W'(MAX_WAIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      gnt_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_gnt_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (ic_req_i || dc_req_i) begin
            mem_req_q  <= 1'b1;
            wait_cnt_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_gnt_q <= pick_dc_d;
`endif
            if (pick_dc_d) begin
              state_q     <= GNT_DC;
              gnt_q       <= 2'b10;
              mem_addr_q  <= {dc_addr_i[ADDR_W-1:4], 4'b0000};
              mem_we_q    <= dc_we_i;
              mem_wdata_q <= dc_we_i ? dc_wdata_i : '0;
            end else begin
              state_q     <= GNT_IC;
              gnt_q       <= 2'b01;
              mem_addr_q  <= {ic_addr_i[ADDR_W-1:4], 4'b0000};
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
            end
          end
        end

        // Request fields stay frozen while granted; the requester's inputs
        // are not looked at again until the next IDLE.
        GNT_IC, GNT_DC: begin
          if (mem_ready_i) begin
            state_q    <= DONE;
            mem_req_q  <= 1'b0;
            gnt_q      <= 2'b00;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Completion is routed combinationally from mem_ready_i to the owner only,
  // so a pulse arriving in IDLE or DONE never reaches either cache.
  assign ic_ready_o = (state_q == GNT_IC) && mem_ready_i;
  assign dc_ready_o = (state_q == GNT_DC) && mem_ready_i;
  assign ic_data_o  = ic_ready_o ? mem_rdata_i : '0;
  assign dc_data_o  = (dc_ready_o && !mem_we_q) ? mem_rdata_i : '0;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign gnt_o       = gnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 128;
  localparam int MAX_WAIT = 8;

  logic              clk;
  logic              rst_n;
  logic              ic_req_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_ready_o;
  logic [LINE_W-1:0] ic_data_o;
  logic              dc_req_i;
  logic              dc_we_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic [LINE_W-1:0] dc_wdata_i;
  logic              dc_ready_o;
  logic [LINE_W-1:0] dc_data_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [LINE_W-1:0] mem_rdata_i;
  logic [1:0]        gnt_o;
  logic              err_o;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .LINE_W  (LINE_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ic_req_i   (ic_req_i),
    .ic_addr_i  (ic_addr_i),
    .ic_ready_o (ic_ready_o),
    .ic_data_o  (ic_data_o),
    .dc_req_i   (dc_req_i),
    .dc_we_i    (dc_we_i),
    .dc_addr_i  (dc_addr_i),
    .dc_wdata_i (dc_wdata_i),
    .dc_ready_o (dc_ready_o),
    .dc_data_o  (dc_data_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i),
    .gnt_o      (gnt_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard of expected completions, in grant order.
  typedef struct {
    logic         is_dc;
    logic [127:0] data;
  } exp_t;
  exp_t sb[$];

  // Memory model: answers a held mem_req_o after mem_lat cycles. The
  // stray_req/stray_seen pair requests a lone ready pulse with no request.
  bit           mem_auto     = 1'b1;
  int           mem_lat      = 3;
  bit           use_addr_pat = 1'b0;
  logic [127:0] mem_pat      = '0;
  int           stray_req    = 0;

  initial begin : mem_model
    int cnt;
    int stray_seen;
    cnt = 0;
    stray_seen = 0;
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready_i = 1'b0;
      mem_rdata_i = '0;
      if (stray_req != stray_seen) begin
        stray_seen++;
        mem_ready_i = 1'b1;
        mem_rdata_i = mem_pat;
        cnt = 0;
      end else if (mem_auto && mem_req_o) begin
        cnt++;
        if (cnt >= mem_lat) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = use_addr_pat ? {4{mem_addr_o}} : mem_pat;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Completion monitor: every ready pulse must match the head of the queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (ic_ready_o || dc_ready_o) begin
        chk("ready_onehot", 128'(ic_ready_o & dc_ready_o), 128'(0));
        if (sb.size() == 0) begin
          chk("unexp_ready", 128'({ic_ready_o, dc_ready_o}), 128'(0));
        end else begin
          e = sb.pop_front();
          chk("rsp_port", 128'(dc_ready_o), 128'(e.is_dc));
          chk("rsp_data", e.is_dc ? dc_data_o : ic_data_o, e.data);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic wait_req();
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (mem_req_o) seen = 1'b1;
    end
    if (!seen) chk("req_timeout", 128'(mem_req_o), 128'(1));
  endtask

  task automatic wait_rdy();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ic_ready_o || dc_ready_o) seen = 1'b1;
    end
    if (!seen) chk("rdy_timeout", 128'(ic_ready_o | dc_ready_o), 128'(1));
  endtask

  task automatic chk_cleared(input string pfx);
    chk({pfx, "_gnt"},      128'(gnt_o),      128'(0));
    chk({pfx, "_mem_req"},  128'(mem_req_o),  128'(0));
    chk({pfx, "_mem_we"},   128'(mem_we_o),   128'(0));
    chk({pfx, "_mem_addr"}, 128'(mem_addr_o), 128'(0));
    chk({pfx, "_mem_wd"},   mem_wdata_o,      128'(0));
    chk({pfx, "_rdy"},      128'({ic_ready_o, dc_ready_o}), 128'(0));
    chk({pfx, "_data"},     ic_data_o | dc_data_o, 128'(0));
    chk({pfx, "_err"},      128'(err_o),      128'(0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  bit ord [3];

  initial begin : stim
    rst_n      = 1'b0;
    ic_req_i   = 1'b0;
    ic_addr_i  = '0;
    dc_req_i   = 1'b0;
    dc_we_i    = 1'b0;
    dc_addr_i  = '0;
    dc_wdata_i = '0;

    #12;
    chk_cleared("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single IC read
    @(posedge clk);
    #1;
    mem_pat   = {16{8'hAA}};
    mem_lat   = 3;
    ic_addr_i = 32'h0000_1234;
    ic_req_i  = 1'b1;
    sb.push_back('{is_dc: 1'b0, data: {16{8'hAA}}});
    wait_req();
    chk("t1_addr", 128'(mem_addr_o), 128'(32'h0000_1230));
    chk("t1_we",   128'(mem_we_o),   128'(0));
    chk("t1_gnt",  128'(gnt_o),      128'(2'b01));
    wait_rdy();
    chk("t1_dc_rdy", 128'(dc_ready_o), 128'(0));
    @(posedge clk);
    #1 ic_req_i = 1'b0;
    @(negedge clk);
    chk("t1_pulse_len", 128'(ic_ready_o), 128'(0));
    chk("t1_bubble_gnt", 128'(gnt_o), 128'(0));

    // DC write-back
    @(posedge clk);
    #1;
    mem_pat    = {4{32'hDEAD_BEEF}};
    dc_we_i    = 1'b1;
    dc_addr_i  = 32'h0000_0040;
    dc_wdata_i = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    dc_req_i   = 1'b1;
    sb.push_back('{is_dc: 1'b1, data: 128'(0)});
    wait_req();
    chk("t2_we",    128'(mem_we_o),   128'(1));
    chk("t2_wdata", mem_wdata_o,      128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
    chk("t2_addr",  128'(mem_addr_o), 128'(32'h40));
    chk("t2_gnt",   128'(gnt_o),      128'(2'b10));
    wait_rdy();
    chk("t2_ic_rdy", 128'(ic_ready_o), 128'(0));
    @(posedge clk);
    #1 dc_req_i = 1'b0;
    dc_we_i = 1'b0;

    // Simultaneous held requests, three back-to-back transfers
    do_reset();
`ifdef MEM_ARB_RR_EN
    ord[0] = 1'b1; ord[1] = 1'b0; ord[2] = 1'b1;
`else
    ord[0] = 1'b1; ord[1] = 1'b1; ord[2] = 1'b1;
`endif
    use_addr_pat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (ord[i]) sb.push_back('{is_dc: 1'b1, data: {4{32'h0000_0200}}});
      else        sb.push_back('{is_dc: 1'b0, data: {4{32'h0000_0100}}});
    end
    ic_addr_i  = 32'h0000_0100;
    dc_addr_i  = 32'h0000_0208;
    dc_wdata_i = {4{32'h5555_AAAA}};
    dc_we_i    = 1'b0;
    ic_req_i   = 1'b1;
    dc_req_i   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_req();
      chk($sformatf("t3_gnt%0d", i), 128'(gnt_o), ord[i] ? 128'(2'b10) : 128'(2'b01));
      chk($sformatf("t3_addr%0d", i), 128'(mem_addr_o),
          ord[i] ? 128'(32'h200) : 128'(32'h100));
      chk($sformatf("t3_wdata%0d", i), mem_wdata_o, 128'(0));
      wait_rdy();
      @(posedge clk);
      #1;
      if (i == 2) begin
        ic_req_i = 1'b0;
        dc_req_i = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("t3_bubble%0d", i), 128'({mem_req_o, gnt_o}), 128'(0));
    end
    use_addr_pat = 1'b0;

    // Address change while granted
    @(posedge clk);
    #1;
    mem_pat   = {8{16'h3C5A}};
    ic_addr_i = 32'h0000_5678;
    ic_req_i  = 1'b1;
    sb.push_back('{is_dc: 1'b0, data: {8{16'h3C5A}}});
    wait_req();
    chk("t4_addr0", 128'(mem_addr_o), 128'(32'h5670));
    @(posedge clk);
    #1 ic_addr_i = 32'h0000_9990;
    @(negedge clk);
    chk("t4_addr1", 128'(mem_addr_o), 128'(32'h5670));
    wait_rdy();
    chk("t4_addr2", 128'(mem_addr_o), 128'(32'h5670));
    @(posedge clk);
    #1 ic_req_i = 1'b0;

    // Timeout: memory answers only after 10 cycles with MAX_WAIT = 8
    @(posedge clk);
    #1;
    mem_lat   = 10;
    mem_pat   = {4{32'h0BAD_F00D}};
    ic_addr_i = 32'h0000_0A00;
    ic_req_i  = 1'b1;
    sb.push_back('{is_dc: 1'b0, data: {4{32'h0BAD_F00D}}});
    wait_req();
    repeat (7) @(negedge clk);
    chk("t5_err_early", 128'(err_o), 128'(0));
    @(negedge clk);
    chk("t5_err_set", 128'(err_o), 128'(1));
    chk("t5_still_req", 128'(mem_req_o), 128'(1));
    wait_rdy();
    @(posedge clk);
    #1 ic_req_i = 1'b0;
    @(negedge clk);
    chk("t5_err_sticky", 128'(err_o), 128'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("t5_err_rst", 128'(err_o), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_lat = 3;

    // Reset in the middle of a DC grant, then a stray memory pulse
    @(posedge clk);
    #1;
    mem_auto   = 1'b0;
    dc_we_i    = 1'b1;
    dc_addr_i  = 32'h0000_0080;
    dc_wdata_i = {4{32'hCAFE_0001}};
    dc_req_i   = 1'b1;
    wait_req();
    chk("t6_gnt", 128'(gnt_o), 128'(2'b10));
    #2 rst_n = 1'b0;
    #1;
    chk_cleared("t6_rst");
    dc_req_i = 1'b0;
    dc_we_i  = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_auto = 1'b1;
    stray_req++;
    @(posedge clk);
    @(negedge clk);
    chk("t6_stray_rdy", 128'({ic_ready_o, dc_ready_o}), 128'(0));
    chk("t6_stray_gnt", 128'(gnt_o), 128'(0));
    @(negedge clk);
    chk("t6_no_req", 128'(mem_req_o), 128'(0));

    repeat (3) @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 128-bit line-fill memory port between the instruction cache (read-only line fills) and the data cache (line fills and write-backs).
- Sits between both caches and the memory model.
- Grants one requester at a time and holds the grant until memory returns a ready pulse.
- Routes the response only to the granted cache; the other cache stalls on its own request.

Parameters:
- ADDR_W, 32, requester/memory address width.
- LINE_W, 128, cache line width in bits.
- MAX_WAIT, 1023, cycles a granted transaction may wait for mem_ready_i before err_o is set.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- ic_req_i  input  1  ICache line-read request; held until ic_ready_o.
- ic_addr_i  input  ADDR_W  ICache request address.
- ic_ready_o  output  1  one-cycle completion pulse to the ICache.
- ic_data_o  output  LINE_W  line data, valid while ic_ready_o=1.
- dc_req_i  input  1  DCache request; held until dc_ready_o.
- dc_we_i  input  1  1 = write-back, 0 = line read.
- dc_addr_i  input  ADDR_W  DCache request address.
- dc_wdata_i  input  LINE_W  write-back line.
- dc_ready_o  output  1  one-cycle completion pulse to the DCache.
- dc_data_o  output  LINE_W  read line data, valid while dc_ready_o=1.
- mem_req_o  output  1  memory request, held until mem_ready_i.
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  ADDR_W  line-aligned address (bits [3:0] forced to 0).
- mem_wdata_o  output  LINE_W  write data.
- mem_ready_i  input  1  one-cycle memory completion pulse.
- mem_rdata_i  input  LINE_W  read line, valid with mem_ready_i.
- gnt_o  output  2  current owner: 01 = IC, 10 = DC, 00 = none.
- err_o  output  1  sticky timeout flag.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; wait_cnt=0; err_o=0; gnt_o=00.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
  - ic_ready_o=0, dc_ready_o=0, ic_data_o=0, dc_data_o=0.
- States: IDLE, GNT_IC, GNT_DC, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both requesting: fixed priority, DC wins.
  - On a grant, in the same clock edge: register mem_addr_o = {addr[ADDR_W-1:4],4'b0}.
  - DC grant also registers mem_we_o=dc_we_i and mem_wdata_o=dc_wdata_i (wdata=0 for reads).
  - IC grant registers mem_we_o=0.
  - Set mem_req_o=1 and gnt_o; next state GNT_IC or GNT_DC.
- GNT_x:
  - mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o are held stable.
  - Address and data are sampled once at grant; later requester changes are ignored.
  - wait_cnt increments each cycle.
  - On mem_ready_i=1, in the same cycle (combinational):
    - x_ready_o=1.
    - x_data_o=mem_rdata_i (all zero for writes).
    - The other port's ready stays 0.
  - At the following edge: mem_req_o=0, gnt_o=00, wait_cnt=0, next state DONE.
- DONE: one bubble cycle with no grant, so the requester can drop its request; next state IDLE.
- Latency: request seen in IDLE → mem_req_o high the next cycle. Best-case round trip = 1 + memory latency + 1 bubble.
- Requester drops req while granted: the transaction still completes and the ready pulse is still issued; the cache ignores it.
- wait_cnt reaching MAX_WAIT in GNT_x: err_o=1 (sticky until reset); the transaction keeps waiting and is not aborted. wait_cnt saturates.
- mem_ready_i in IDLE or DONE: ignored; no ready output is raised.
- Reset mid-transaction: immediate return to IDLE with all outputs cleared; any in-flight memory response is dropped.
- Invariant: mem_req_o=1 exactly when state is GNT_IC or GNT_DC. At most one of ic_ready_o/dc_ready_o is high.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration for simultaneous requests.
  - Register last_gnt (reset = IC, so the first tie goes to DC).
  - On a tie, grant the requester that was not granted last.
  - last_gnt updates on every grant.
- Not defined: fixed priority, DC over IC; no last_gnt register.

Test Plan:
- Single IC read: ic_req_i=1, ic_addr_i=0x0000_1234; memory returns 0xAAAA..AA after 3 cycles.
  - Expect mem_addr_o=0x0000_1230, mem_we_o=0, gnt_o=01.
  - ic_ready_o one-cycle pulse with ic_data_o=0xAAAA..AA; dc_ready_o=0 throughout.
- DC write-back: dc_req_i=1, dc_we_i=1, dc_addr_i=0x40, dc_wdata_i=0x1122..FF.
  - Expect mem_we_o=1, mem_wdata_o=0x1122..FF, mem_addr_o=0x40.
  - dc_ready_o pulses on mem_ready_i; dc_data_o=0.
- Simultaneous requests held for 3 back-to-back transactions:
  - Without MEM_ARB_RR_EN: grant order DC,DC,DC.
  - With MEM_ARB_RR_EN: grant order DC,IC,DC.
  - Each grant is separated by one DONE bubble.
- Address change mid-grant: change ic_addr_i to 0x9990 while in GNT_IC.
  - mem_addr_o stays at the originally sampled line address until mem_ready_i.
- Timeout with MAX_WAIT=8: hold mem_ready_i=0 for 10 cycles.
  - err_o rises after cycle 8 and stays high after mem_ready_i completes the transfer.
  - Reset clears err_o.
- Reset mid-operation: assert rst_n=0 during GNT_DC.
  - All outputs 0 and gnt_o=00 immediately.
  - A mem_ready_i pulse after reset release produces no ready output.
